// File: rtl/alu_operand_stage_if.sv
// Bundle for the ALU operand stage: issue request, operand output handshake and
// register writeback. The stage uses the slave view; upstream drives the master view.
interface alu_operand_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [XLEN-1:0] imm;
  logic            use_imm;
  logic [1:0]      sel_in;

  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [1:0]      sel;
  logic            out_valid;
  logic            out_ready;

  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  modport master (
    output in_valid, rs1, rs2, imm, use_imm, sel_in, out_ready, wb_en, wb_rd, wb_data,
    input  in_ready, a, b, sel, out_valid
  );

  modport slave (
    input  in_valid, rs1, rs2, imm, use_imm, sel_in, out_ready, wb_en, wb_rd, wb_data,
    output in_ready, a, b, sel, out_valid
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Operand fetch stage: register file with writeback bypass feeding a single-entry
// output register with valid/ready handshake toward the ALU.
module alu_operand_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input logic               clk,
  input logic               rst,
  alu_operand_stage_if.slave bus
);
  localparam int IW = $clog2(NREG);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  logic [XLEN-1:0] rf [NREG];
  state_t          state;
  state_t          state_nx;
  logic            load;
  logic            wb_hit;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [1:0]      sel_q;

  // x0 and indices beyond the implemented file are read-as-zero, write-ignored.
  function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
    if (idx != 5'd0 && int'(idx) < NREG) return rf[idx[IW-1:0]];
    return '0;
  endfunction

  assign wb_hit = bus.wb_en && (bus.wb_rd != 5'd0) && (int'(bus.wb_rd) < NREG);

  always_comb begin
    op_a = (wb_hit && bus.wb_rd == bus.rs1) ? bus.wb_data : rf_read(bus.rs1);
    if (bus.use_imm)                         op_b = bus.imm;
    else if (wb_hit && bus.wb_rd == bus.rs2) op_b = bus.wb_data;
    else                                     op_b = rf_read(bus.rs2);
  end

  // NOTE: the architectural registers must come up zeroed, so the array gets an
  // explicit reset loop; without it the file would power up with garbage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_hit) begin
      rf[bus.wb_rd[IW-1:0]] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nx;
  end

  // NOTE: every output of this block is given a default first so that no path
  // through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      EMPTY: begin
        if (bus.in_valid) begin
          load     = 1'b1;
          state_nx = FULL;
        end
      end
      FULL: begin
        if (bus.out_ready) begin
          if (bus.in_valid) load     = 1'b1;
          else              state_nx = EMPTY;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  // NOTE: state is written with <= so every flop samples pre-edge values and
  // the simulated order of always_ff blocks cannot change the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sel_q <= 2'b00;
    end else if (load) begin
      a_q   <= op_a;
      b_q   <= op_b;
      sel_q <= bus.sel_in;
    end
  end

  assign bus.in_ready  = (state == EMPTY) || bus.out_ready;
  assign bus.out_valid = (state == FULL);
  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.sel       = sel_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed table-driven bench for alu_operand_stage: each record is one clock of
// stimulus with the in_ready expected before the edge and outputs expected after it.
module tb_alu_operand_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_operand_stage_if #(.XLEN(32)) bus ();

  alu_operand_stage #(.XLEN(32), .NREG(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Field order for positional literals:
  // iv rs1 rs2 imm use_imm sel_in ordy | wb_en wb_rd wb_data | exp_rdy exp_ov chk exp_a exp_b exp_sel
  typedef struct {
    logic        iv;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        use_imm;
    logic [1:0]  sel_in;
    logic        ordy;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exp_rdy;
    logic        exp_ov;
    logic        chk;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [1:0]  exp_sel;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.in_valid  = v.iv;
    bus.rs1       = v.rs1;
    bus.rs2       = v.rs2;
    bus.imm       = v.imm;
    bus.use_imm   = v.use_imm;
    bus.sel_in    = v.sel_in;
    bus.out_ready = v.ordy;
    bus.wb_en     = v.wb_en;
    bus.wb_rd     = v.wb_rd;
    bus.wb_data   = v.wb_data;
  endtask

  task automatic run_vec(input string name, input vec_t v);
    drive(v);
    #1;
    check({name, ".in_ready"}, 32'(bus.in_ready), 32'(v.exp_rdy));
    @(posedge clk);
    #1;
    check({name, ".out_valid"}, 32'(bus.out_valid), 32'(v.exp_ov));
    if (v.chk) begin
      check({name, ".a"},   bus.a,          v.exp_a);
      check({name, ".b"},   bus.b,          v.exp_b);
      check({name, ".sel"}, 32'(bus.sel),   32'(v.exp_sel));
    end
  endtask

  vec_t vecs [9];
  vec_t v;

  initial begin
    vecs[0] = '{1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 2'd0, 1'b1, 1'b1, 5'd1, 32'h0000FFFF,
                1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 2'd0};
    vecs[1] = '{1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 2'd0, 1'b1, 1'b1, 5'd2, 32'hFFFF0000,
                1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 2'd0};
    vecs[2] = '{1'b1, 5'd1, 5'd2, 32'h0, 1'b0, 2'd0, 1'b1, 1'b0, 5'd0, 32'h0,
                1'b1, 1'b1, 1'b1, 32'h0000FFFF, 32'hFFFF0000, 2'd0};
    vecs[3] = '{1'b1, 5'd3, 5'd0, 32'hFFFF0828, 1'b1, 2'd1, 1'b1, 1'b1, 5'd3, 32'hFFFF5828,
                1'b1, 1'b1, 1'b1, 32'hFFFF5828, 32'hFFFF0828, 2'd1};
    // Consume without a new issue: operands may be stale, only out_valid is defined.
    vecs[4] = '{1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 2'd0, 1'b1, 1'b1, 5'd0, 32'h0A0A0A0A,
                1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0};
    vecs[5] = '{1'b1, 5'd0, 5'd0, 32'h0, 1'b0, 2'd2, 1'b1, 1'b1, 5'd0, 32'h0A0A0A0A,
                1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 2'd2};
    vecs[6] = '{1'b1, 5'd1, 5'd4, 32'h0, 1'b0, 2'd3, 1'b1, 1'b1, 5'd4, 32'h12345678,
                1'b1, 1'b1, 1'b1, 32'h0000FFFF, 32'h12345678, 2'd3};
    vecs[7] = '{1'b1, 5'd4, 5'd3, 32'h0, 1'b0, 2'd0, 1'b1, 1'b0, 5'd0, 32'h0,
                1'b1, 1'b1, 1'b1, 32'h12345678, 32'hFFFF5828, 2'd0};
    vecs[8] = '{1'b1, 5'd1, 5'd1, 32'h0, 1'b0, 2'd1, 1'b1, 1'b1, 5'd1, 32'h11111111,
                1'b1, 1'b1, 1'b1, 32'h11111111, 32'h11111111, 2'd1};

    v = '{1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 32'h0,
          1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 2'd0};
    drive(v);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset.out_valid", 32'(bus.out_valid), 32'd0);
    check("reset.a", bus.a, 32'h0);
    check("reset.b", bus.b, 32'h0);
    check("reset.sel", 32'(bus.sel), 32'd0);
    check("reset.in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Stall: new issue offered with different operands, writeback of x5 proceeds.
    v = '{1'b1, 5'd2, 5'd3, 32'h0, 1'b0, 2'd2, 1'b0, 1'b1, 5'd5, 32'hF0F0F0F0,
          1'b0, 1'b1, 1'b1, 32'h11111111, 32'h11111111, 2'd1};
    for (int i = 0; i < 3; i++) begin
      run_vec($sformatf("stall%0d", i), v);
      v.wb_en = 1'b0;
    end
    v.ordy    = 1'b1;
    v.exp_rdy = 1'b1;
    v.exp_a   = 32'hFFFF0000;
    v.exp_b   = 32'hFFFF5828;
    v.exp_sel = 2'd2;
    run_vec("release", v);

    // Back-to-back full-throughput issues reading x5 written during the stall.
    for (int i = 0; i < 4; i++) begin
      v = '{1'b1, 5'd5, 5'd0, 32'h100 + 32'(i), 1'b1, 2'(i), 1'b1, 1'b0, 5'd0, 32'h0,
            1'b1, 1'b1, 1'b1, 32'hF0F0F0F0, 32'h100 + 32'(i), 2'(i)};
      run_vec($sformatf("b2b%0d", i), v);
    end
    v = '{1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 2'd0, 1'b1, 1'b0, 5'd0, 32'h0,
          1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0};
    run_vec("drain", v);

    // Reset while FULL, competing with an issue and a writeback.
    v = '{1'b1, 5'd5, 5'd1, 32'h0, 1'b0, 2'd3, 1'b0, 1'b0, 5'd0, 32'h0,
          1'b1, 1'b1, 1'b1, 32'hF0F0F0F0, 32'h11111111, 2'd3};
    run_vec("fill", v);
    rst = 1'b1;
    v = '{1'b1, 5'd2, 5'd2, 32'h0, 1'b0, 2'd2, 1'b0, 1'b1, 5'd6, 32'hDEADBEEF,
          1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 2'd0};
    run_vec("rst_full", v);
    rst = 1'b0;
    v = '{1'b1, 5'd5, 5'd6, 32'h0, 1'b0, 2'd1, 1'b0, 1'b0, 5'd0, 32'h0,
          1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 2'd1};
    run_vec("post_rst", v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter XLEN, default 32, data width of registers and operands.
REQ-002 Parameter NREG, default 32, number of architectural registers; x0 included.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  issue request carries valid rs1/rs2/imm/use_imm/sel_in.
REQ-006 in_ready  output  1  stage accepts issue request this cycle.
REQ-007 rs1  input  5  source register index for operand a.
REQ-008 rs2  input  5  source register index for operand b.
REQ-009 imm  input  XLEN  immediate operand.
REQ-010 use_imm  input  1  1: b_out takes imm; 0: b_out takes register rs2.
REQ-011 sel_in  input  2  ALU operation select, passed through unchanged.
REQ-012 a  output  XLEN  registered operand a to ALU.
REQ-013 b  output  XLEN  registered operand b to ALU.
REQ-014 sel  output  2  registered ALU select.
REQ-015 out_valid  output  1  a/b/sel hold a valid operation.
REQ-016 out_ready  input  1  ALU consumes the operation this cycle.
REQ-017 wb_en  input  1  register write enable.
REQ-018 wb_rd  input  5  destination register index.
REQ-019 wb_data  input  XLEN  write data (ALU result).

Function
REQ-020 Register file SHALL hold NREG x XLEN entries; read combinationally, write on clk rising edge when wb_en=1 and wb_rd!=0.
REQ-021 x0 SHALL read 0 always; writes to x0 SHALL be ignored.
REQ-022 Bypass: when wb_en=1, wb_rd!=0 and wb_rd equals rs1 (rs2), operand capture SHALL use wb_data instead of stored value in the same cycle.
REQ-023 Output register SHALL be a single-entry skid-free pipeline stage; in_ready = !out_valid || out_ready.
REQ-024 On in_valid && in_ready: a, b, sel SHALL load next edge and out_valid SHALL be 1; latency issue-to-output exactly 1 cycle.
REQ-025 On out_valid && out_ready with no new accept: out_valid SHALL go 0 next edge; a/b/sel MAY hold stale values.
REQ-026 Simultaneous consume and accept: new operation SHALL replace old in one cycle, out_valid stays 1 (full throughput, 1 op/cycle).
REQ-027 Stall: while out_valid=1 and out_ready=0, a, b, sel, out_valid SHALL hold unchanged regardless of in_valid or writeback activity.
REQ-028 Writeback SHALL proceed during stalls; held operands are NOT refreshed (hazard resolution is upstream's responsibility).
REQ-029 Index values >= NREG (when NREG<32) SHALL read 0 and writes SHALL be ignored.
REQ-030 Two states only: EMPTY (out_valid=0) and FULL (out_valid=1); EMPTY->FULL on accept; FULL->EMPTY on consume without accept; FULL->FULL on stall or consume+accept.

Reset
REQ-031 With rst=1 at a rising edge: all registers x1..xNREG-1 SHALL clear to 0; a, b = 0; sel = 2'b00; out_valid = 0.
REQ-032 Reset SHALL take priority over wb_en and in_valid in the same cycle; an operation in flight SHALL be discarded.
REQ-033 in_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-034 Write x1=0x0000FFFF, x2=0xFFFF0000; issue rs1=1, rs2=2, use_imm=0, sel_in=00, out_ready=1 -> next cycle a=0x0000FFFF, b=0xFFFF0000, sel=00, out_valid=1.
REQ-035 Same-cycle wb_en=1, wb_rd=3, wb_data=0xFFFF5828 with issue rs1=3, use_imm=1, imm=0xFFFF0828, sel_in=01 -> a=0xFFFF5828, b=0xFFFF0828 (bypass).
REQ-036 Write x0=0x0A0A0A0A, then issue rs1=0, rs2=0 -> a=0, b=0.
REQ-037 out_valid=1, out_ready=0 for 3 cycles with new in_valid and different operands -> in_ready=0, a/b/sel unchanged; release out_ready -> next op loaded one cycle later.
REQ-038 Back-to-back issues with out_ready=1 for 4 cycles -> 4 distinct outputs on consecutive cycles, out_valid continuously 1.
REQ-039 Assert rst while FULL with x5=0xF0F0F0F0 -> next cycle out_valid=0, a=b=0, and reading x5 returns 0.
